// File: rtl/reg_pipe_stage.sv
// One pipeline slot: a valid bit plus a data register. Data only loads when the
// incoming slot is valid, so bubbles never toggle the data flops.
module reg_pipe_stage #(
  parameter int            DW        = 32,
  parameter logic [DW-1:0] RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          adv_i,
  input  logic          src_v_i,
  input  logic [DW-1:0] src_d_i,
  output logic          v_o,
  output logic [DW-1:0] d_o
);

  logic          v_q, v_d;
  logic [DW-1:0] d_q, d_d;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush_i) begin
      v_d = 1'b0;
    end else if (adv_i) begin
      v_d = src_v_i;
      if (src_v_i) d_d = src_d_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= 1'b0;
      d_q <= RESET_VAL;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v_o = v_q;
  assign d_o = d_q;

endmodule

// File: rtl/reg_pipe_hs.sv
// DEPTH-stage valid/ready register pipeline with selectable bubble-collapsing or
// lockstep stalling, synchronous flush and an occupancy count.
module reg_pipe_hs #(
  parameter int            DW        = 32,
  parameter int            DEPTH     = 2,
  parameter logic [DW-1:0] RESET_VAL = '0,
  parameter bit            COLLAPSE  = 1'b1,
  parameter string         REG_NAME  = "reg_pipe_hs"
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DW-1:0]              in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0]         v, adv, src_v;
  logic [DEPTH-1:0][DW-1:0] d, src_d;
  logic [CW-1:0]            cnt_d;

  // Tail advances when it is empty or being drained; upstream stages either
  // fill holes independently or follow the tail as one block.
  assign adv[DEPTH-1] = out_ready | ~v[DEPTH-1];

  for (genvar g = 0; g < DEPTH-1; g++) begin : g_adv
    if (COLLAPSE) begin : g_col
      assign adv[g] = ~v[g] | adv[g+1];
    end else begin : g_lck
      assign adv[g] = adv[DEPTH-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stg
    if (g == 0) begin : g_head
      assign src_v[g] = in_valid;
      assign src_d[g] = in_data;
    end else begin : g_body
      assign src_v[g] = v[g-1];
      assign src_d[g] = d[g-1];
    end

    reg_pipe_stage #(
      .DW        (DW),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush),
      .adv_i   (adv[g]),
      .src_v_i (src_v[g]),
      .src_d_i (src_d[g]),
      .v_o     (v[g]),
      .d_o     (d[g])
    );
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) cnt_d = cnt_d + CW'(v[i]);
  end

  assign in_ready  = adv[0] & ~flush;
  assign out_valid = v[DEPTH-1] & ~flush;
  assign out_data  = d[DEPTH-1];
  assign count     = cnt_d;

`ifndef SYNTHESIS
  // Simulation-only X checks on the control inputs once out of reset.
  always @(posedge clk) begin
    if (rst) begin
      assert (!$isunknown(in_valid))  else $error("%s: X on in_valid", REG_NAME);
      assert (!$isunknown(out_ready)) else $error("%s: X on out_ready", REG_NAME);
      assert (!$isunknown(flush))     else $error("%s: X on flush", REG_NAME);
    end
  end
`endif

endmodule

// File: tb/tb_reg_pipe_hs.sv
// Bench for reg_pipe_hs: a collapsing and a lockstep instance share stimulus and
// are checked against a slot-level reference model, tables and hand sequences.
module tb_reg_pipe_hs;
  localparam int            DW    = 8;
  localparam int            DEPTH = 3;
  localparam int            CW    = 2;
  localparam logic [DW-1:0] RV    = 8'hC3;

  logic          clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          ir_c, ov_c, ir_l, ov_l;
  logic [DW-1:0] od_c, od_l;
  logic [CW-1:0] cnt_c, cnt_l;

  always #5 clk = ~clk;

  reg_pipe_hs #(.DW(DW), .DEPTH(DEPTH), .RESET_VAL(RV), .COLLAPSE(1'b1), .REG_NAME("col")) u_col (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_c), .in_data(in_data),
    .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c), .count(cnt_c));

  reg_pipe_hs #(.DW(DW), .DEPTH(DEPTH), .RESET_VAL(RV), .COLLAPSE(1'b0), .REG_NAME("lck")) u_lck (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_l), .in_data(in_data),
    .out_valid(ov_l), .out_ready(out_ready), .out_data(od_l), .count(cnt_l));

  int total = 0;
  int bad   = 0;

  // Reference slots, [0] = collapsing, [1] = lockstep.
  logic          mv[2][DEPTH];
  logic [DW-1:0] md[2][DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A slot may move if the consumer drains, or (collapsing) any slot at or
  // beyond it is empty, or (lockstep) the last slot is empty.
  function automatic bit m_moves(int m, int i, bit ordy);
    if (ordy) return 1'b1;
    if (m == 1) return !mv[m][DEPTH-1];
    for (int j = i; j < DEPTH; j++) if (!mv[m][j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_occ(int m);
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(mv[m][i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < DEPTH; i++) begin
        mv[m][i] = 1'b0;
        md[m][i] = RV;
      end
  endtask

  task automatic model_check(input string tag);
    for (int m = 0; m < 2; m++) begin
      logic          e_ov, e_ir, a_ov, a_ir;
      logic [DW-1:0] a_od;
      logic [CW-1:0] a_cnt;
      string         nm;
      e_ov  = mv[m][DEPTH-1] & ~flush;
      e_ir  = m_moves(m, 0, out_ready) & ~flush;
      a_ov  = (m == 0) ? ov_c  : ov_l;
      a_ir  = (m == 0) ? ir_c  : ir_l;
      a_od  = (m == 0) ? od_c  : od_l;
      a_cnt = (m == 0) ? cnt_c : cnt_l;
      nm    = (m == 0) ? "col" : "lck";
      chk({tag, ".", nm, ".out_valid"}, 32'(a_ov), 32'(e_ov));
      chk({tag, ".", nm, ".in_ready"},  32'(a_ir), 32'(e_ir));
      chk({tag, ".", nm, ".out_data"},  32'(a_od), 32'(md[m][DEPTH-1]));
      chk({tag, ".", nm, ".count"},     32'(a_cnt), 32'(m_occ(m)));
    end
  endtask

  // Compute next model state from current inputs, cross the edge, commit.
  task automatic advance();
    logic          nv[2][DEPTH];
    logic [DW-1:0] nd[2][DEPTH];
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < DEPTH; i++) begin
        logic          sv;
        logic [DW-1:0] sd;
        sv = (i == 0) ? in_valid : mv[m][i-1];
        sd = (i == 0) ? in_data  : md[m][i-1];
        nv[m][i] = mv[m][i];
        nd[m][i] = md[m][i];
        if (flush) nv[m][i] = 1'b0;
        else if (m_moves(m, i, out_ready)) begin
          nv[m][i] = sv;
          if (sv) nd[m][i] = sd;
        end
      end
    @(posedge clk);
    #1;
    mv = nv;
    md = nd;
  endtask

  task automatic drive(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic fl);
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    #3;
  endtask

  task automatic cyc(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic fl,
                     input string tag);
    drive(iv, id, ordy, fl);
    model_check(tag);
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
  endtask

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic          fl;
    logic          ov;
    logic [DW-1:0] od;
    logic [CW-1:0] cnt;
    logic          ir;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // Stream 11/22/33 with the consumer always ready.
    vecs[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, RV,    2'd0, 1'b1};
    vecs[1] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b0, RV,    2'd1, 1'b1};
    vecs[2] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, RV,    2'd2, 1'b1};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 2'd3, 1'b1};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 2'd2, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 2'd1, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h33, 2'd0, 1'b1};

    do_reset();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("reset.out_valid", 32'(ov_c), 32'd0);
    chk("reset.out_data",  32'(od_c), 32'(RV));
    chk("reset.count",     32'(cnt_c), 32'd0);
    chk("reset.in_ready",  32'(ir_c), 32'd1);
    model_check("reset");
    advance();

    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive(vecs[k].iv, vecs[k].id, vecs[k].ordy, vecs[k].fl);
      chk($sformatf("vec%0d.col.out_valid", k), 32'(ov_c),  32'(vecs[k].ov));
      chk($sformatf("vec%0d.col.out_data", k),  32'(od_c),  32'(vecs[k].od));
      chk($sformatf("vec%0d.col.count", k),     32'(cnt_c), 32'(vecs[k].cnt));
      chk($sformatf("vec%0d.col.in_ready", k),  32'(ir_c),  32'(vecs[k].ir));
      chk($sformatf("vec%0d.lck.out_data", k),  32'(od_l),  32'(vecs[k].od));
      advance();
    end

    // Fill with a stalled consumer, then one simultaneous in/out transfer.
    do_reset();
    cyc(1'b1, 8'hA1, 1'b0, 1'b0, "fill0");
    cyc(1'b1, 8'hA2, 1'b0, 1'b0, "fill1");
    cyc(1'b1, 8'hA3, 1'b0, 1'b0, "fill2");
    drive(1'b1, 8'hA4, 1'b0, 1'b0);
    chk("full.in_ready", 32'(ir_c), 32'd0);
    chk("full.count",    32'(cnt_c), 32'd3);
    chk("full.out_data", 32'(od_c), 32'hA1);
    model_check("full");
    advance();
    drive(1'b1, 8'hA4, 1'b1, 1'b0);
    chk("swap.in_ready", 32'(ir_c), 32'd1);
    chk("swap.out_data", 32'(od_c), 32'hA1);
    model_check("swap");
    advance();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("swap_after.count",    32'(cnt_c), 32'd3);
    chk("swap_after.out_data", 32'(od_c), 32'hA2);
    model_check("swap_after");
    advance();

    // Build {v,_,v} then stall: collapsing fills the hole, lockstep keeps it.
    do_reset();
    cyc(1'b1, 8'hB1, 1'b1, 1'b0, "bub0");
    cyc(1'b0, 8'h00, 1'b1, 1'b0, "bub1");
    cyc(1'b1, 8'hB2, 1'b1, 1'b0, "bub2");
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("bub_stall.col.in_ready", 32'(ir_c), 32'd1);
    chk("bub_stall.lck.in_ready", 32'(ir_l), 32'd0);
    model_check("bub_stall");
    advance();
    drive(1'b1, 8'hB3, 1'b0, 1'b0);
    chk("bub_next.col.in_ready", 32'(ir_c), 32'd1);
    chk("bub_next.lck.in_ready", 32'(ir_l), 32'd0);
    chk("bub_next.col.count",    32'(cnt_c), 32'd2);
    model_check("bub_next");
    advance();
    for (int k = 0; k < 5; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0, "bub_drain");

    // Flush with two words in flight while both sides try to transfer.
    do_reset();
    cyc(1'b1, 8'hF1, 1'b0, 1'b0, "fl0");
    cyc(1'b1, 8'hF2, 1'b0, 1'b0, "fl1");
    drive(1'b1, 8'hF3, 1'b1, 1'b1);
    chk("flush.in_ready",  32'(ir_c), 32'd0);
    chk("flush.out_valid", 32'(ov_c), 32'd0);
    chk("flush.count",     32'(cnt_c), 32'd2);
    model_check("flush");
    advance();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_after.count", 32'(cnt_c), 32'd0);
    model_check("flush_after");
    advance();
    for (int k = 0; k < 4; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0, "flush_idle");

    // Asynchronous reset between edges, then latency of a fresh word.
    do_reset();
    cyc(1'b1, 8'hE1, 1'b0, 1'b0, "ar0");
    cyc(1'b1, 8'hE2, 1'b0, 1'b0, "ar1");
    cyc(1'b1, 8'hE3, 1'b0, 1'b0, "ar2");
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst.out_valid", 32'(ov_c), 32'd0);
    chk("async_rst.count",     32'(cnt_c), 32'd0);
    chk("async_rst.lck.count", 32'(cnt_l), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1'b1, 8'h5A, 1'b1, 1'b0, "ar_push");
    begin
      int n = 1;
      bit seen = 1'b0;
      while (n <= 10) begin
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        if (ov_c) begin seen = 1'b1; break; end
        model_check("ar_wait");
        advance();
        n++;
      end
      if (seen) begin
        chk("ar_latency",  32'(n), 32'(DEPTH));
        chk("ar_out_data", 32'(od_c), 32'h5A);
        model_check("ar_out");
        advance();
      end else begin
        chk("ar_timeout", 32'd0, 32'd1);
      end
    end

    // Randomised traffic with a lightly then heavily stalled consumer.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      logic          iv, ordy, fl;
      logic [DW-1:0] id;
      iv   = ($urandom % 4) != 0;
      id   = DW'($urandom);
      ordy = ($urandom % 100) < ((k < 300) ? 75 : 25);
      fl   = ($urandom % 30) == 0;
      cyc(iv, id, ordy, fl, $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
